// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: program memory with sequential host load, fetch register and registered decode for the TPU controller
module instr_fetch_decode #(
  parameter int DEPTH = 256,
  parameter int INSTR_W = 28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_clear,
  output logic               load_ready,
  output logic [8:0]         prog_len,
  input  logic               INSBUF_en,
  input  logic               DECODER_en,
  input  logic [7:0]         pc,
  output logic [3:0]         func,
  output logic [9:0]         rs1,
  output logic [9:0]         rs2,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  output logic               illegal_op,
  output logic               halted
);
  typedef enum logic [1:0] {LOAD, RUN, HALTED} state_t;
  localparam logic [INSTR_W-1:0] HALT_W = 28'hFF0000F;
  state_t state, next;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] fetch_q;
  logic [7:0] wr_ptr;
  logic [7:0] code;
  logic legal, is_halt, run, do_write, do_clear;
  // next-state and load-port qualifiers; clear beats write, start beats clear when leaving HALTED
  always_comb begin
    code = {fetch_q[27:24], fetch_q[3:0]};
    legal = code inside {8'h12, 8'h22, 8'h11, 8'h14, 8'hFF};
    is_halt = code == 8'hFF;
    run = state == RUN;
    load_ready = state == LOAD && prog_len < 9'(DEPTH);
    do_clear = load_clear && (state == LOAD || (state == HALTED && !start));
    do_write = load_valid && load_ready && !load_clear;
    next = state;
    case (state)
      LOAD:    next = (start && !load_clear && prog_len != 9'd0) ? RUN : LOAD;
      RUN:     next = (DECODER_en && (is_halt || !legal)) ? HALTED : RUN;
      HALTED:  next = start ? RUN : load_clear ? LOAD : HALTED;
      default: next = LOAD;
    endcase
  end
  // program memory write port, no reset so it maps onto plain RAM
  always_ff @(posedge clk)
    if (reset && do_write) mem[wr_ptr] <= load_data;
  // state, load pointers, fetch register and decoded outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LOAD;
      wr_ptr <= '0;
      prog_len <= '0;
      fetch_q <= '0;
      func <= '0;
      rs1 <= '0;
      rs2 <= '0;
      opcode <= '0;
      instr_valid <= 1'b0;
      illegal_op <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= next;
      if (do_clear) begin
        wr_ptr <= '0;
        prog_len <= '0;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + 8'd1;
        prog_len <= prog_len + 9'd1;
      end
      if (run && INSBUF_en) fetch_q <= ({1'b0, pc} < prog_len) ? mem[pc] : HALT_W;
      if (run && DECODER_en) begin
        func <= legal ? fetch_q[27:24] : 4'hF;
        opcode <= legal ? fetch_q[3:0] : 4'hF;
        rs1 <= fetch_q[23:14];
        rs2 <= fetch_q[13:4];
        instr_valid <= 1'b1;
        illegal_op <= !legal;
        halted <= is_halt || !legal;
      end
      if (state == HALTED && start) begin
        halted <= 1'b0;
        instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: table-driven and scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;
  logic clk = 0, reset = 0, start = 0, load_valid = 0, load_clear = 0;
  logic INSBUF_en = 0, DECODER_en = 0;
  logic [27:0] load_data = '0;
  logic [7:0] pc = '0;
  logic load_ready, instr_valid, illegal_op, halted;
  logic [8:0] prog_len;
  logic [3:0] func, opcode;
  logic [9:0] rs1, rs2;
  int n_chk = 0, n_err = 0;

  instr_fetch_decode dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_clear(load_clear), .load_ready(load_ready),
    .prog_len(prog_len), .INSBUF_en(INSBUF_en), .DECODER_en(DECODER_en),
    .pc(pc), .func(func), .rs1(rs1), .rs2(rs2), .opcode(opcode),
    .instr_valid(instr_valid), .illegal_op(illegal_op), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] f;
    logic [9:0] r1;
    logic [9:0] r2;
    logic [3:0] op;
    logic ill;
    logic hlt;
    logic ch;
    logic iv;
  } exp_t;
  typedef struct {
    logic ld;
    logic [27:0] w;
    exp_t e;
  } vec_t;

  exp_t sbq[$];
  exp_t got;
  logic dec_q = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // outputs are compared in the cycle after each decode strobe
  always @(posedge clk) dec_q <= DECODER_en;
  always @(negedge clk)
    if (dec_q && sbq.size() > 0) begin
      got = sbq.pop_front();
      chk("func", 32'(func), 32'(got.f));
      chk("rs1", 32'(rs1), 32'(got.r1));
      chk("rs2", 32'(rs2), 32'(got.r2));
      chk("opcode", 32'(opcode), 32'(got.op));
      chk("illegal_op", 32'(illegal_op), 32'(got.ill));
      chk("instr_valid", 32'(instr_valid), 32'(got.iv));
      if (got.ch) chk("halted", 32'(halted), 32'(got.hlt));
    end

  task automatic load1(input logic [27:0] w);
    @(negedge clk); load_valid = 1; load_data = w;
    @(negedge clk); load_valid = 0;
  endtask
  task automatic do_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask
  task automatic do_clear();
    @(negedge clk); load_clear = 1;
    @(negedge clk); load_clear = 0;
  endtask
  task automatic do_reset();
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
  endtask
  task automatic fd(input logic [7:0] p, input exp_t e);
    @(negedge clk); INSBUF_en = 1; pc = p;
    @(negedge clk); INSBUF_en = 0; DECODER_en = 1; sbq.push_back(e);
    @(negedge clk); DECODER_en = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[5];
    exp_t hx, ex_ill, ez, e;
    exp_t exa[3];
    tv[0] = '{1'b1, {4'h1, 10'h040, 10'h080, 4'h2}, '{4'h1, 10'h040, 10'h080, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1}};
    tv[1] = '{1'b1, {4'h2, 10'h3FF, 10'h001, 4'h2}, '{4'h2, 10'h3FF, 10'h001, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1}};
    tv[2] = '{1'b1, {4'h1, 10'h155, 10'h2AA, 4'h1}, '{4'h1, 10'h155, 10'h2AA, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1}};
    tv[3] = '{1'b1, {4'h1, 10'h000, 10'h3FF, 4'h4}, '{4'h1, 10'h000, 10'h3FF, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1}};
    tv[4] = '{1'b0, 28'h0, '{4'hF, 10'h3C0, 10'h000, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1}};
    hx = tv[4].e;
    ex_ill = '{4'hF, 10'h123, 10'h321, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1};
    ez = '{4'h0, 10'h0, 10'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    // reset values
    repeat (2) @(negedge clk);
    reset = 1;
    chk("rst func", 32'(func), 0);
    chk("rst rs1", 32'(rs1), 0);
    chk("rst opcode", 32'(opcode), 0);
    chk("rst instr_valid", 32'(instr_valid), 0);
    chk("rst illegal_op", 32'(illegal_op), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst prog_len", 32'(prog_len), 0);
    chk("rst load_ready", 32'(load_ready), 1);
    // strobes and start on an empty program are ignored
    fd(8'd0, ez);
    do_start();
    chk("empty start load_ready", 32'(load_ready), 1);
    fd(8'd0, ez);
    // table: four legal words, then one fetch past the end returns HALT
    for (int i = 0; i < 5; i++) if (tv[i].ld) load1(tv[i].w);
    chk("tbl prog_len", 32'(prog_len), 4);
    do_start();
    chk("tbl run load_ready", 32'(load_ready), 0);
    for (int i = 0; i < 5; i++) fd(8'(i), tv[i].e);
    chk("tbl halted load_ready", 32'(load_ready), 0);
    // restart from HALTED clears halted/instr_valid, program reruns
    do_start();
    chk("restart halted", 32'(halted), 0);
    chk("restart instr_valid", 32'(instr_valid), 0);
    fd(8'd1, tv[1].e);
    fd(8'd9, hx);
    // clear from HALTED, pipelined fetch+decode with an explicit HALT word
    do_clear();
    chk("clear prog_len", 32'(prog_len), 0);
    chk("clear load_ready", 32'(load_ready), 1);
    load1(tv[0].w);
    load1(tv[2].w);
    load1(28'hFF0000F);
    chk("pipe prog_len", 32'(prog_len), 3);
    do_start();
    exa[0] = tv[0].e; exa[1] = tv[2].e; exa[2] = hx;
    @(negedge clk); INSBUF_en = 1; pc = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      pc = 8'(i); INSBUF_en = i < 3; DECODER_en = 1; sbq.push_back(exa[i-1]);
    end
    @(negedge clk); DECODER_en = 0; INSBUF_en = 0;
    @(negedge clk);
    // illegal code halts and forces FF; a later legal decode clears illegal_op
    do_clear();
    load1({4'h3, 10'h123, 10'h321, 4'h3});
    do_start();
    fd(8'd0, ex_ill);
    chk("ill load_ready", 32'(load_ready), 0);
    do_clear();
    chk("ill clear load_ready", 32'(load_ready), 1);
    load1(tv[0].w);
    do_start();
    e = tv[0].e; e.ch = 0;
    fd(8'd0, e);
    // fill all 256 entries, 257th write dropped
    do_reset();
    for (int i = 0; i < 256; i++) load1({4'h1, 2'b0, 8'(i), 2'b0, ~8'(i), 4'h1});
    chk("full prog_len", 32'(prog_len), 256);
    chk("full load_ready", 32'(load_ready), 0);
    load1(28'hFF0000F);
    chk("over prog_len", 32'(prog_len), 256);
    do_start();
    fd(8'd255, '{4'h1, 10'h0FF, 10'h000, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1});
    fd(8'd0, '{4'h1, 10'h000, 10'h0FF, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1});
    // write and clear together: clear wins
    do_reset();
    for (int i = 0; i < 5; i++) load1(tv[1].w);
    chk("five prog_len", 32'(prog_len), 5);
    @(negedge clk); load_valid = 1; load_clear = 1; load_data = tv[3].w;
    @(negedge clk); load_valid = 0; load_clear = 0;
    chk("clr+wr prog_len", 32'(prog_len), 0);
    chk("clr+wr load_ready", 32'(load_ready), 1);
    load1(tv[2].w);
    chk("after clr prog_len", 32'(prog_len), 1);
    do_start();
    fd(8'd0, tv[2].e);
    // reset mid-run after pc1 decode
    do_reset();
    load1(tv[0].w);
    load1(tv[2].w);
    load1(28'hFF0000F);
    do_start();
    fd(8'd0, tv[0].e);
    fd(8'd1, tv[2].e);
    do_reset();
    chk("mid instr_valid", 32'(instr_valid), 0);
    chk("mid func", 32'(func), 0);
    chk("mid prog_len", 32'(prog_len), 0);
    chk("mid load_ready", 32'(load_ready), 1);
    fd(8'd2, ez);
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
